// File: rtl/matrix_seq_pkg.sv
// Shared definitions for the matrix phase sequencer.
// Holds the phase count, the phase index constants, the error codes,
// the sequencer state type and a one-hot helper.
package matrix_seq_pkg;

  localparam int NUM_PHASES = 6;

  localparam logic [2:0] PH_IMPORT    = 3'd0;
  localparam logic [2:0] PH_CALCC     = 3'd1;
  localparam logic [2:0] PH_DETB      = 3'd2;
  localparam logic [2:0] PH_TRANSPOSE = 3'd3;
  localparam logic [2:0] PH_INVERSE   = 3'd4;
  localparam logic [2:0] PH_MULTIPLY  = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_DET_ZERO = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SPURIOUS = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FINISH,
    ERROR
  } seqState_t;

  // One-hot mask selecting phase idx.
  function automatic logic [NUM_PHASES-1:0] phaseMask(input logic [2:0] idx);
    return {{(NUM_PHASES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/matrix_phase_sequencer_if.sv
// Handshake bundle between the sequencer and the phase controllers.
// master: host/phase side (drives start, abort, phase_done, det_zero).
// slave : sequencer side (drives phase_start, phase_active, busy, done,
//         err, err_code, cycles).
interface matrix_phase_sequencer_if
  import matrix_seq_pkg::*;
#(
  parameter int CW = 16
) ();

  logic                  start;
  logic                  abort;
  logic [NUM_PHASES-1:0] phase_done;
  logic                  det_zero;
  logic [NUM_PHASES-1:0] phase_start;
  logic [NUM_PHASES-1:0] phase_active;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  logic [CW-1:0]         cycles;

  modport master (
    output start, abort, phase_done, det_zero,
    input  phase_start, phase_active, busy, done, err, err_code, cycles
  );

  modport slave (
    input  start, abort, phase_done, det_zero,
    output phase_start, phase_active, busy, done, err, err_code, cycles
  );

endinterface

// File: rtl/phase_watchdog.sv
// Per-phase watchdog for the matrix phase sequencer.
// Ports: clk, rst_n (async active-low), clear (restart count),
//        enable (count this cycle), expired (TIMEOUT-th enabled cycle
//        reached without a clear).
module phase_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // count holds the number of enabled cycles already completed, so the
  // TIMEOUT-th enabled cycle is the one where count == TIMEOUT-1.
  assign expired = enable && (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/matrix_phase_sequencer.sv
// Matrix phase sequencer: launches the six matrix phases in order
// (import, calC, detB, transpose, inverse, multiply), watches each phase
// for completion, a zero determinant, a timeout or a stray done bit,
// and counts busy cycles of the run.
// Ports: clk, rst_n (async active-low), bus (slave side of
//        matrix_phase_sequencer_if carrying the run handshake and status).
module matrix_phase_sequencer
  import matrix_seq_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  matrix_phase_sequencer_if.slave bus
);

  seqState_t             state, nextState;
  logic [2:0]            k, nextK;
  logic [1:0]            errCode, nextErrCode;
  logic                  clearCycles;
  logic [NUM_PHASES-1:0] curMask;
  logic [NUM_PHASES-1:0] strayDone;
  logic                  wdExpired;
  logic                  nextBusy;

  logic [NUM_PHASES-1:0] phaseStart;
  logic [NUM_PHASES-1:0] phaseActive;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [CW-1:0]         cycles;

  assign curMask   = phaseMask(k);
  assign strayDone = bus.phase_done & ~curMask;

  phase_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == LAUNCH),
    .enable (state == WAIT),
    .expired(wdExpired)
  );

  // Next-state decision. Priority: abort, stray done, valid done
  // (det_zero check on detB), then watchdog expiry.
  always_comb begin
    nextState   = state;
    nextK       = k;
    nextErrCode = errCode;
    clearCycles = 1'b0;
    if (bus.abort) begin
      nextState   = IDLE;
      nextErrCode = ERR_NONE;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (bus.start) begin
            nextState   = LAUNCH;
            nextK       = PH_IMPORT;
            nextErrCode = ERR_NONE;
            clearCycles = 1'b1;
          end
        end
        LAUNCH: begin
          if (|strayDone) begin
            nextState   = ERROR;
            nextErrCode = ERR_SPURIOUS;
          end else begin
            nextState = WAIT;
          end
        end
        WAIT: begin
          if (|strayDone) begin
            nextState   = ERROR;
            nextErrCode = ERR_SPURIOUS;
          end else if (|(bus.phase_done & curMask)) begin
            if (k == PH_DETB && bus.det_zero) begin
              nextState   = ERROR;
              nextErrCode = ERR_DET_ZERO;
            end else if (k == PH_MULTIPLY) begin
              nextState = FINISH;
            end else begin
              nextState = LAUNCH;
              nextK     = k + 3'd1;
            end
          end else if (wdExpired) begin
            nextState   = ERROR;
            nextErrCode = ERR_TIMEOUT;
          end
        end
        FINISH:  nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  assign nextBusy = (nextState == LAUNCH) || (nextState == WAIT);

  // State and all outputs are registered from the next-state decision so
  // no input reaches an output combinationally. cycles freezes on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= PH_IMPORT;
      errCode     <= ERR_NONE;
      phaseStart  <= '0;
      phaseActive <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cycles      <= '0;
    end else begin
      state       <= nextState;
      k           <= nextK;
      errCode     <= nextErrCode;
      phaseStart  <= (nextState == LAUNCH) ? phaseMask(nextK) : '0;
      phaseActive <= nextBusy ? phaseMask(nextK) : '0;
      busy        <= nextBusy;
      done        <= (nextState == FINISH);
      err         <= (nextState == ERROR);
      if (clearCycles) begin
        cycles <= '0;
      end else if (busy && !bus.abort && (cycles != '1)) begin
        cycles <= cycles + CW'(1);
      end
    end
  end

  assign bus.phase_start  = phaseStart;
  assign bus.phase_active = phaseActive;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err;
  assign bus.err_code     = errCode;
  assign bus.cycles       = cycles;

endmodule

// File: doc/matrix_phase_sequencer.md
MATRIX_PHASE_SEQUENCER -- requirements
Module: matrix_phase_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles allowed per phase from its start pulse before a timeout error.
REQ-002 Parameter: CW, default 16, width of the run cycle counter.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  run request; sampled only in IDLE or ERROR.
REQ-006 Port: abort  in  1  forces return to IDLE from any state.
REQ-007 Port: phase_done  in  6  per-phase done: bit0 import, bit1 calC, bit2 detB, bit3 transpose, bit4 inverse, bit5 multiply.
REQ-008 Port: det_zero  in  1  determinant-zero flag from the datapath.
REQ-009 Port: phase_start  out  6  one-cycle start pulse to the selected phase controller.
REQ-010 Port: phase_active  out  6  one-hot level marking the phase in progress.
REQ-011 Port: busy  out  1  high while any phase is active.
REQ-012 Port: done  out  1  one-cycle pulse when the multiply phase completes.
REQ-013 Port: err  out  1  high in the ERROR state.
REQ-014 Port: err_code  out  2  00 none, 01 det_zero, 10 timeout, 11 spurious done.
REQ-015 Port: cycles  out  CW  busy-cycle count of the last or current run; saturating.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, WAIT, FINISH and ERROR, plus a 3-bit phase index k.
REQ-017 IDLE with start=1 SHALL set k=0 and go to LAUNCH; cycles SHALL clear to 0.
REQ-018 LAUNCH SHALL drive phase_start[k]=1 for exactly one cycle, then go to WAIT.
REQ-019 phase_active[k] and busy SHALL be high from the LAUNCH cycle through the cycle in which phase_done[k] is sampled high.
REQ-020 In WAIT, phase_done[k]=1 with k<5 SHALL increment k and go to LAUNCH, so the next phase_start occurs one cycle after the done.
REQ-021 In WAIT, phase_done[5]=1 SHALL go to FINISH; FINISH SHALL pulse done for one cycle with busy=0, then return to IDLE.
REQ-022 When k=2 and det_zero=1 in the phase_done[2] cycle, the FSM SHALL go to ERROR with err_code=01, and no further phase SHALL start.
REQ-023 A per-phase watchdog SHALL clear on LAUNCH; when it reaches TIMEOUT cycles in WAIT without phase_done[k], the FSM SHALL go to ERROR with err_code=10.
REQ-024 If phase_done[k] and the timeout occur in the same cycle, done SHALL win.
REQ-025 Any phase_done bit other than bit k that is high while busy SHALL cause ERROR with err_code=11; this check SHALL take priority over a simultaneous valid done.
REQ-026 phase_done bits seen in IDLE or ERROR SHALL be ignored.
REQ-027 ERROR SHALL hold err=1 and err_code; start there SHALL clear err and err_code to 00 and begin a new run as in IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort SHALL take priority over every other input: next state IDLE, err_code=00, no pulses that cycle; cycles holds.
REQ-030 cycles SHALL increment each busy cycle, saturate at all-ones and hold after the run ends.
REQ-031 All outputs SHALL be registered or decoded only from registered state; no combinational input-to-output paths.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, k=0, phase_start=0, phase_active=0, busy=0, done=0, err=0, err_code=00, cycles=0, watchdog=0.
REQ-033 Reset mid-run SHALL abandon the run; after release the block SHALL wait for a fresh start.

Structure
REQ-034 Shared package matrix_seq_pkg SHALL hold NUM_PHASES=6, the phase index constants, the err_code constants and the state enum typedef.
REQ-035 The watchdog SHALL be the sub-module phase_watchdog (clear, enable, TIMEOUT parameter, expired output); everything else stays in one module.

Verification
REQ-036 Normal run: start at cycle 0, each phase_done 3 cycles after its phase_start -> phase_start[0..5] at cycles 1,5,9,13,17,21; done at 25; cycles=24; err=0.
REQ-037 det_zero: det_zero=1 with phase_done[2] at cycle 12 -> err=1 and err_code=01 at cycle 13; phase_start[3] never asserted.
REQ-038 Timeout: TIMEOUT=8 and phase_done[0] withheld -> err_code=10 exactly 8 WAIT cycles after phase_start[0]; a later start clears err and relaunches phase 0.
REQ-039 Spurious done: phase_done[4] during phase 1 -> err_code=11; phase_done[1] in the same cycle also gives 11.
REQ-040 Reset/abort: rst_n low in phase 3 -> all outputs zero asynchronously; abort in phase 4 -> IDLE next cycle, done never pulses, cycles holds its value.
